// File: rtl/mem.sv
// mem: memory-access pipeline stage driving a handshaked data RAM for loads and stores
// clk/rst: clock and active-low synchronous reset
// ex_*: operation from EX/MEM; mem_*: result to MEM/WB
// ram_*: data RAM request/response; stall_req freezes upstream; mem_excp flags misalignment or bus timeout
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_reg,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  output logic        mem_reg,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        stall_req,
  output logic        mem_excp
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        berr_q, berr_d;
  logic        is_byte, is_half, is_word, is_load, is_store, is_mem, misal, go;
  logic        idle, done, req;
  logic [3:0]  sel;
  logic [31:0] lane, ld_data;
  always_comb begin
    is_byte  = ex_memop == 4'd1 || ex_memop == 4'd2 || ex_memop == 4'd6;
    is_half  = ex_memop == 4'd3 || ex_memop == 4'd4 || ex_memop == 4'd7;
    is_word  = ex_memop == 4'd5 || ex_memop == 4'd8;
    is_load  = ex_memop >= 4'd1 && ex_memop <= 4'd5;
    is_store = ex_memop >= 4'd6 && ex_memop <= 4'd8;
    is_mem   = is_load || is_store;
    misal    = (is_half && ex_addr[0]) || (is_word && ex_addr[1:0] != 2'b00);
    go       = is_mem && !misal;
    idle     = state_q == IDLE;
    done     = state_q == DONE;
    req      = rst && ((idle && go) || state_q == WAIT);
    sel      = is_byte ? 4'b0001 << ex_addr[1:0] : is_half ? (ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // shifting by the byte offset puts the addressed lane(s) at bit 0; halfwords are aligned so this also works for them
    lane     = rbuf_q >> {ex_addr[1:0], 3'b000};
    ld_data  = ex_memop == 4'd1 ? {{24{lane[7]}}, lane[7:0]} :
               ex_memop == 4'd2 ? {24'd0, lane[7:0]} :
               ex_memop == 4'd3 ? {{16{lane[15]}}, lane[15:0]} :
               ex_memop == 4'd4 ? {16'd0, lane[15:0]} : rbuf_q;
  end
  always_comb begin
    ram_req   = req;
    stall_req = req;
    ram_we    = req && is_store;
    ram_addr  = req ? {ex_addr[31:2], 2'b00} : 32'd0;
    ram_sel   = req ? sel : 4'd0;
    ram_wdata = !req ? 32'd0 : is_byte ? {4{ex_sdata[7:0]}} : is_half ? {2{ex_sdata[15:0]}} : ex_sdata;
    mem_reg   = rst && (idle ? ex_reg && !is_mem : done && ex_reg && is_load && !berr_q);
    mem_waddr = rst ? ex_waddr : 5'd0;
    mem_wdata = !rst ? 32'd0 : done ? ld_data : ex_wdata;
    mem_excp  = rst && ((idle && is_mem && misal) || (done && berr_q));
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        state_d = go ? WAIT : IDLE;
        cnt_d   = go ? 4'd0 : cnt_q;
      end
      WAIT: begin
        state_d = ram_ack || cnt_q == 4'd15 ? DONE : WAIT;
        rbuf_d  = ram_ack ? ram_rdata : rbuf_q;
        berr_d  = !ram_ack && cnt_q == 4'd15;
        cnt_d   = ram_ack ? cnt_q : cnt_q + 4'd1;
      end
      DONE: begin
        state_d = IDLE;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rbuf_q  <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      berr_q  <= berr_d;
    end
  end
endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 The block SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst  input  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
REQ-003 The block SHALL have ports: ex_reg  input  1  register write enable from EX/MEM.
REQ-004 The block SHALL have ports: ex_waddr  input  5  destination register; ex_wdata  input  32  ALU result.
REQ-005 The block SHALL have ports: ex_memop  input  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP.
REQ-006 The block SHALL have ports: ex_addr  input  32  byte address; ex_sdata  input  32  store data.
REQ-007 The block SHALL have ports: mem_reg  output  1, mem_waddr  output  5, mem_wdata  output  32  to MEM/WB register.
REQ-008 The block SHALL have ports: ram_req, ram_we  output  1; ram_addr  output  32; ram_sel  output  4; ram_wdata  output  32.
REQ-009 The block SHALL have ports: ram_rdata  input  32; ram_ack  input  1  data RAM completion.
REQ-010 The block SHALL have ports: stall_req  output  1  freeze upstream stages; mem_excp  output  1  alignment/bus error.

Function
REQ-011 FSM SHALL have states IDLE, WAIT, DONE; a 4-bit timeout counter; a 32-bit read buffer rbuf.
REQ-012 IDLE, non-memory op: mem_reg/mem_waddr/mem_wdata SHALL equal ex_reg/ex_waddr/ex_wdata combinationally; stall_req=0; ram_req=0.
REQ-013 Misalignment SHALL be: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-014 IDLE, misaligned op: mem_excp=1, mem_reg=0, ram_req=0, stall_req=0, state stays IDLE.
REQ-015 IDLE, aligned memory op: ram_req=1, stall_req=1, counter cleared, next state WAIT.
REQ-016 ram_ack SHALL be sampled only in WAIT; ack in IDLE or DONE is ignored.
REQ-017 WAIT: ram_req=1, stall_req=1; on ram_ack=1 latch ram_rdata into rbuf, next state DONE; else counter increments.
REQ-018 WAIT with counter=15 and no ack (16th WAIT cycle) SHALL set a sticky bus-error flag and go to DONE.
REQ-019 DONE: ram_req=0, stall_req=0, next state IDLE unconditionally.
REQ-020 DONE, load without bus error: mem_reg=ex_reg, mem_waddr=ex_waddr, mem_wdata=extended rbuf data.
REQ-021 DONE, store or bus error: mem_reg=0; mem_excp=1 only for bus error; bus-error flag cleared on leaving DONE.
REQ-022 Byte order SHALL be little-endian: lane k = ram_sel[k] = bits 8k+7:8k, selected by addr[1:0].
REQ-023 ram_addr SHALL be {ex_addr[31:2],2'b00} whenever ram_req=1, else 0.
REQ-024 ram_sel: byte ops one-hot on addr[1:0]; halfword 0011 (addr[1]=0) or 1100; word 1111; 0 when ram_req=0.
REQ-025 ram_wdata: SB {4{sdata[7:0]}}, SH {2{sdata[15:0]}}, SW sdata; ram_we=1 only for stores with ram_req=1.
REQ-026 Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane(s) to 32 bits; LW uses rbuf unchanged.
REQ-027 Upstream SHALL hold ex_* inputs stable while stall_req=1; the block relies on ex_* in DONE.

Reset
REQ-028 While rst=0 at a clk edge: state=IDLE, counter=0, rbuf=0, bus-error flag=0.
REQ-029 While rst=0 all outputs SHALL be 0 combinationally (mem_reg, mem_waddr, mem_wdata, ram_*, stall_req, mem_excp).
REQ-030 Reset in WAIT SHALL abandon the access: ram_req=0 from the reset cycle; a later ram_ack SHALL be ignored.

Verification
REQ-031 memop=0, ex_reg=1, waddr=5, wdata=0x00001234 -> same cycle mem_reg=1, mem_waddr=5, mem_wdata=0x00001234, stall_req=0, ram_req=0.
REQ-032 LB addr 0x00000103, ack in 2nd WAIT cycle, ram_rdata=0x80FF0000 -> ram_addr=0x00000100, ram_sel=1000, stall_req high 3 cycles, DONE mem_wdata=0xFFFFFF80.
REQ-033 SH addr 0x00002002, sdata=0x0000ABCD -> ram_we=1, ram_sel=1100, ram_wdata=0xABCDABCD; DONE mem_reg=0, mem_excp=0.
REQ-034 LW addr 0x00001001 -> mem_excp=1, mem_reg=0, ram_req=0, stall_req=0, state IDLE.
REQ-035 LW addr 0x00000040, ram_ack never -> 16 WAIT cycles then DONE with mem_excp=1, mem_reg=0, ram_req=0; IDLE next.
REQ-036 LHU addr 0x00000006, rst=0 in 1st WAIT cycle, ack next cycle -> state IDLE, ram_req=0, stall_req=0, no write-back issued.
